// File: rtl/dense_w_fetch_ctrl.sv
// dense_w_fetch_ctrl
//   Walks the dense-layer weight ROM, neuron-major, and streams every weight to
//   the dense MAC over valid/ready. The ROM has a 1-cycle registered read, so a
//   2-entry buffer plus a credit check keeps issue at full rate when the MAC is
//   always ready, and never overflows when it stalls.
// Ports
//   clk, rst_n         clock (rising edge), async active-low reset
//   start              pulse, begins a pass from IDLE only
//   busy / done        high in RUN/DRAIN / one-cycle end-of-pass pulse
//   rom_ena, rom_addr  ROM read request
//   rom_q              ROM data, valid the cycle after rom_ena
//   w_data, w_valid, w_ready, w_neuron, w_last
//                      weight stream to the MAC (handshake = w_valid & w_ready)
module dense_w_fetch_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int N_IN       = 16,
  parameter int N_OUT      = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rom_ena,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0]   rom_q,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [$clog2(N_OUT):0]  w_neuron,
  output logic                    w_last
);

  localparam int TOTAL = N_IN * N_OUT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int IW    = $clog2(N_IN) + 1;
  localparam int NW    = $clog2(N_OUT) + 1;

  if (N_IN < 1 || N_OUT < 1 || (BASE_ADDR + N_IN * N_OUT) > (2 ** ADDR_WIDTH)) begin : g_param_err
    $error("dense_w_fetch_ctrl: weight block does not fit the ROM or N_IN/N_OUT < 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_nstate;

  logic [CW-1:0]  r_issue_cnt;
  logic [IW-1:0]  r_in_idx;
  logic [NW-1:0]  r_nrn_idx;

  // tags of the word currently inside the ROM pipeline
  logic           r_inflight;
  logic [NW-1:0]  r_fl_nrn;
  logic           r_fl_last;

  logic [1:0][DATA_WIDTH-1:0] r_buf_data;
  logic [1:0][NW-1:0]         r_buf_nrn;
  logic [1:0]                 r_buf_last;
  logic                       r_head, r_tail;
  logic [1:0]                 r_cnt;

  logic           w_pop, w_push, w_issue, w_start_pass, w_in_wrap;
  logic [2:0]     w_occ;

  assign w_valid  = (r_cnt != 2'd0);
  assign w_data   = r_buf_data[r_head];
  assign w_neuron = r_buf_nrn[r_head];
  assign w_last   = r_buf_last[r_head];

  assign w_pop  = w_valid & w_ready;
  assign w_push = r_inflight;

  // Occupancy after this cycle's pop; counting the pop as credit is what lets a
  // held-high w_ready sustain one word per cycle with only two entries.
  assign w_occ   = {1'b0, r_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue = (r_state == S_RUN) && (r_issue_cnt < CW'(TOTAL)) && (w_occ < 3'd2);

  assign rom_ena  = w_issue;
  assign rom_addr = w_issue ? (ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_issue_cnt)) : '0;

  assign w_start_pass = (r_state == S_IDLE) && start;
  assign w_in_wrap    = (r_in_idx == IW'(N_IN - 1));

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_nstate = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (r_issue_cnt == CW'(TOTAL)) w_nstate = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_cnt == 2'd0 && !r_inflight) w_nstate = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // Issue-side address and tag counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
      r_in_idx    <= '0;
      r_nrn_idx   <= '0;
    end else if (w_start_pass) begin
      r_issue_cnt <= '0;
      r_in_idx    <= '0;
      r_nrn_idx   <= '0;
    end else if (w_issue) begin
      r_issue_cnt <= r_issue_cnt + CW'(1);
      if (w_in_wrap) begin
        r_in_idx  <= '0;
        r_nrn_idx <= r_nrn_idx + NW'(1);
      end else begin
        r_in_idx  <= r_in_idx + IW'(1);
      end
    end
  end

  // Tags ride alongside the ROM read so they meet rom_q at the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_fl_nrn   <= '0;
      r_fl_last  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fl_nrn  <= r_nrn_idx;
        r_fl_last <= w_in_wrap;
      end
    end
  end

  // 2-entry output FIFO; rom_q is only sampled when a read was in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_data <= '0;
      r_buf_nrn  <= '0;
      r_buf_last <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_data[r_tail] <= rom_q;
        r_buf_nrn[r_tail]  <= r_fl_nrn;
        r_buf_last[r_tail] <= r_fl_last;
        r_tail             <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_w_fetch_ctrl.sv
// Directed bench: N_IN=4, N_OUT=3, BASE_ADDR=0x10 with ROM[a]=a, plus a
// second 1x1 instance for the single-word corner.
module tb_dense_w_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, w_ready = 1'b0;
  logic       busy, done, rom_ena, w_valid, w_last;
  logic [7:0] rom_addr, rom_q, w_data;
  logic [2:0] w_neuron;

  logic       s_start = 1'b0, s_ready = 1'b0;
  logic       s_busy, s_done, s_ena, s_valid, s_last;
  logic [7:0] s_addr, s_q, s_data;
  logic [0:0] s_neuron;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  dense_w_fetch_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .N_IN(4), .N_OUT(3), .BASE_ADDR(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rom_ena(rom_ena), .rom_addr(rom_addr), .rom_q(rom_q),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .w_neuron(w_neuron), .w_last(w_last));

  dense_w_fetch_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .N_IN(1), .N_OUT(1), .BASE_ADDR(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .rom_ena(s_ena), .rom_addr(s_addr), .rom_q(s_q),
    .w_data(s_data), .w_valid(s_valid), .w_ready(s_ready),
    .w_neuron(s_neuron), .w_last(s_last));

  // ROM models: registered read, zero when not enabled
  always_ff @(posedge clk) begin
    rom_q <= rom_ena ? rom_addr : 8'h00;
    s_q   <= s_ena   ? s_addr   : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // mode 0: ready high, 1: ready toggles, 2: ready low for 10 cycles.
  // inject: extra start pulses at words 3, 7 and in DONE.
  // abort_at >= 0: pull reset when that many words have been delivered.
  task automatic run_pass(input int mode, input bit inject, input int abort_at);
    int n_iss = 0, n_pop = 0, n_done = 0, ena_early = 0, tail = 0;
    bit prev_stall = 0, seen_done = 0, inj3 = 0, inj7 = 0, pop;
    logic [11:0] prev_word, exp_word;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      start = (c == 0);
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = (c % 2 == 0);
        default: w_ready = (c >= 10);
      endcase
      if (inject && n_pop == 3 && !inj3) begin start = 1'b1; inj3 = 1; end
      if (inject && n_pop == 7 && !inj7) begin start = 1'b1; inj7 = 1; end
      if (abort_at >= 0 && n_pop == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("reset_mid", {busy, done, rom_ena, w_valid, w_last, rom_addr, w_data, w_neuron}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      #1;
      if (c == 1) begin
        chk("lat_ena", {rom_ena, rom_addr}, {1'b1, 8'h10});
        chk("busy_run", busy, 1);
      end
      if (c == 2) chk("lat_vld0", w_valid, 0);
      if (c == 3) chk("lat_vld1", w_valid, 1);
      if (prev_stall) chk("stall", {w_data, w_neuron, w_last}, prev_word);
      pop = w_valid && w_ready;
      if (rom_ena) chk("addr", rom_addr, 8'h10 + n_iss);
      if (n_iss - n_pop - int'(pop) >= 2) chk("credit", rom_ena, 0);
      if (mode == 2 && c < 10 && rom_ena) ena_early++;
      if (pop) begin
        exp_word = {8'(8'h10 + n_pop), 3'(n_pop / 4), 1'(n_pop % 4 == 3)};
        chk("word", {w_data, w_neuron, w_last}, exp_word);
        n_pop++;
      end
      if (rom_ena) n_iss++;
      prev_stall = w_valid && !w_ready;
      prev_word  = {w_data, w_neuron, w_last};
      if (done) begin
        n_done++;
        seen_done = 1;
        if (inject) start = 1'b1;
      end
      if (seen_done) begin
        tail++;
        if (tail > 3) break;
      end
    end
    start = 1'b0;
    chk("nwords", n_pop, 12);
    chk("ndone", n_done, 1);
    chk("busy_after", busy, 0);
    if (mode == 2) chk("ena_early", ena_early, 2);
  endtask

  initial begin
    int nw = 0, nd = 0;
    #12;
    chk("rst_out", {busy, done, rom_ena, w_valid, w_last, rom_addr, w_data, w_neuron}, 32'h0);
    chk("rst_out1", {s_busy, s_done, s_ena, s_valid, s_last, s_addr, s_data, s_neuron}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_pass(0, 0, -1);   // full rate
    run_pass(1, 0, -1);   // toggling ready
    run_pass(2, 0, -1);   // long initial stall
    run_pass(0, 1, -1);   // stray starts ignored
    run_pass(0, 0, -1);   // restart from 0x10 after the ignored starts
    run_pass(0, 0, 5);    // reset during word 5
    @(negedge clk);
    #1 chk("no_stale", {w_valid, busy}, 0);
    run_pass(0, 0, -1);   // fresh pass after reset

    // single-word instance
    s_ready = 1'b1;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (s_valid) begin
        chk("one_word", {s_data, s_neuron, s_last}, {8'h10, 1'b0, 1'b1});
        nw++;
      end
      if (s_done) nd++;
      @(negedge clk);
    end
    chk("one_nwords", nw, 1);
    chk("one_ndone", nd, 1);
    chk("one_busy", s_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
